// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: boot warm-up, stalls, redirects, halt.
// Optional perf counters enabled with `define FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam state_t REDIR_NEXT = (FLUSH_CYCLES > 0) ? FLUSH : RUN;

    state_t           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             redirect;

    // A taken branch is honoured in RUN and, defensively, in FLUSH.
    assign redirect = !rst && branch_taken && (st_q == RUN || st_q == FLUSH);
    assign state    = st_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= BOOT;
            cnt_q <= '0;
        end else begin
            unique case (st_q)
                BOOT: begin
                    if (cnt_q == BOOT_LAST) begin
                        st_q  <= RUN;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        st_q  <= REDIR_NEXT;
                        cnt_q <= '0;
                    end else if (halt_req) begin
                        st_q <= HALT;
                    end
                end
                FLUSH: begin
                    if (branch_taken) begin
                        st_q  <= REDIR_NEXT;
                        cnt_q <= '0;
                    end else if (cnt_q == FLUSH_LAST) begin
                        st_q  <= RUN;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HALT: begin
                    if (resume) begin
                        st_q <= RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        fetch_valid = 1'b0;
        if (!rst) begin
            unique case (st_q)
                BOOT: begin
                end
                RUN: begin
                    if (branch_taken) begin
                        pc_we   = 1'b1;
                        pc_sel  = 1'b1;
                        ifid_we = 1'b1;
                    end else if (halt_req) begin
                        ifid_we    = 1'b1;
                        idex_flush = 1'b0;
                    end else if (stall_req) begin
                        ifid_flush  = 1'b0;
                        fetch_valid = 1'b1;
                    end else begin
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        ifid_flush  = 1'b0;
                        idex_flush  = 1'b0;
                        fetch_valid = 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_we = 1'b1;
                    if (branch_taken) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end else begin
                        idex_flush = 1'b0;
                    end
                end
                HALT: begin
                    ifid_we    = 1'b1;
                    idex_flush = 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic        stall_hit;
    logic [31:0] stall_q;
    logic [31:0] redir_q;

    assign stall_hit = !rst && st_q == RUN && stall_req
                       && !branch_taken && !halt_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (stall_hit) stall_q <= stall_q + 32'd1;
            if (redirect)  redir_q <= redir_q + 32'd1;
        end
    end

    assign perf_stall_cnt    = stall_q;
    assign perf_redirect_cnt = redir_q;
`else
    logic unused_redirect;
    assign unused_redirect   = redirect;
    assign perf_stall_cnt    = '0;
    assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed vectors, queued expectations.
// Runs a FLUSH_CYCLES=1 instance and a FLUSH_CYCLES=0 instance side by side.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] RSTO = 6'b000110;
    localparam logic [5:0] BTO  = 6'b000110;
    localparam logic [5:0] NRM  = 6'b101001;
    localparam logic [5:0] STL  = 6'b000011;
    localparam logic [5:0] RED  = 6'b111110;
    localparam logic [5:0] HLD  = 6'b001100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall_req = 1'b0;
    logic branch_taken = 1'b0;
    logic halt_req = 1'b0;
    logic resume = 1'b0;

    logic        pc_we0, pc_sel0, ifid_we0, ifid_flush0, idex_flush0, fv0;
    logic [1:0]  state0;
    logic [31:0] sc0, rc0;
    logic        pc_we1, pc_sel1, ifid_we1, ifid_flush1, idex_flush1, fv1;
    logic [1:0]  state1;
    logic [31:0] sc1, rc1;

    always #5 clk = ~clk;

    fetch_ctrl #(.BOOT_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
        .pc_we(pc_we0), .pc_sel(pc_sel0), .ifid_we(ifid_we0),
        .ifid_flush(ifid_flush0), .idex_flush(idex_flush0),
        .fetch_valid(fv0), .state(state0),
        .perf_stall_cnt(sc0), .perf_redirect_cnt(rc0)
    );

    fetch_ctrl #(.BOOT_CYCLES(2), .FLUSH_CYCLES(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
        .pc_we(pc_we1), .pc_sel(pc_sel1), .ifid_we(ifid_we1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
        .fetch_valid(fv1), .state(state1),
        .perf_stall_cnt(sc1), .perf_redirect_cnt(rc1)
    );

    typedef struct {
        logic [5:0]  o;
        logic [1:0]  st;
        logic [31:0] s;
        logic [31:0] r;
        logic [1:0]  st1;
        logic        pw1;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        if ($isunknown(exp)) return;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("outs", {26'd0, pc_we0, pc_sel0, ifid_we0, ifid_flush0,
                         idex_flush0, fv0}, {26'd0, e.o});
            chk("state", {30'd0, state0}, {30'd0, e.st});
            chk("stall_cnt", sc0, e.s);
            chk("redir_cnt", rc0, e.r);
            chk("state_f0", {30'd0, state1}, {30'd0, e.st1});
            chk("pc_we_f0", {31'd0, pc_we1}, {31'd0, e.pw1});
        end
    end

    task automatic step(input logic r_, input logic sr, input logic bt,
                        input logic hr, input logic rs,
                        input logic [1:0] st, input logic [5:0] o,
                        input logic [31:0] s, input logic [31:0] rc,
                        input logic [1:0] st1, input logic pw1);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r_;
        stall_req    = sr;
        branch_taken = bt;
        halt_req     = hr;
        resume       = rs;
        e.o   = o;
        e.st  = st;
        e.s   = PERF ? s : 32'd0;
        e.r   = PERF ? rc : 32'd0;
        e.st1 = st1;
        e.pw1 = pw1;
        q.push_back(e);
    endtask

    initial begin
        // reset and boot warm-up
        step(1,0,0,0,0, 2'bx, RSTO, 32'bx, 32'bx, 2'bx, 0);
        step(1,0,0,0,0, 0, RSTO, 0, 0, 0, 0);
        step(1,0,0,0,0, 0, RSTO, 0, 0, 0, 0);
        step(0,0,0,0,0, 0, BTO,  0, 0, 0, 0);
        step(0,0,0,0,0, 0, BTO,  0, 0, 0, 0);
        step(0,0,0,0,0, 1, NRM,  0, 0, 1, 1);
        // three-cycle load-use stall
        step(0,1,0,0,0, 1, STL,  0, 0, 1, 0);
        step(0,1,0,0,0, 1, STL,  1, 0, 1, 0);
        step(0,1,0,0,0, 1, STL,  2, 0, 1, 0);
        step(0,0,0,0,0, 1, NRM,  3, 0, 1, 1);
        // redirect with flush recovery
        step(0,0,1,0,0, 1, RED,  3, 0, 1, 1);
        step(0,0,0,0,0, 2, HLD,  3, 1, 1, 1);
        step(0,0,0,0,0, 1, NRM,  3, 1, 1, 1);
        // branch beats halt and stall
        step(0,1,1,1,0, 1, RED,  3, 1, 1, 1);
        step(0,0,0,0,0, 2, HLD,  3, 2, 1, 1);
        step(0,0,0,0,0, 1, NRM,  3, 2, 1, 1);
        // halt, ignored requests, resume beats halt
        step(0,0,0,1,0, 1, HLD,  3, 2, 1, 0);
        step(0,0,0,0,0, 3, HLD,  3, 2, 3, 0);
        step(0,1,1,0,0, 3, HLD,  3, 2, 3, 0);
        step(0,0,0,1,0, 3, HLD,  3, 2, 3, 0);
        step(0,0,0,0,0, 3, HLD,  3, 2, 3, 0);
        step(0,0,0,0,0, 3, HLD,  3, 2, 3, 0);
        step(0,0,0,1,1, 3, HLD,  3, 2, 3, 0);
        step(0,0,0,0,0, 1, NRM,  3, 2, 1, 1);
        // reset while in FLUSH
        step(0,0,1,0,0, 1, RED,  3, 2, 1, 1);
        step(1,0,0,0,0, 2, RSTO, 3, 3, 1, 0);
        step(0,0,0,0,0, 0, BTO,  0, 0, 0, 0);
        step(0,0,0,0,0, 0, BTO,  0, 0, 0, 0);
        step(0,0,0,0,0, 1, NRM,  0, 0, 1, 1);
        // reset while in HALT
        step(0,0,0,1,0, 1, HLD,  0, 0, 1, 0);
        step(1,0,0,0,0, 3, RSTO, 0, 0, 3, 0);
        step(0,0,0,0,0, 0, BTO,  0, 0, 0, 0);
        step(0,0,0,0,0, 0, BTO,  0, 0, 0, 0);
        step(0,0,0,0,0, 1, NRM,  0, 0, 1, 1);
        // back-to-back branch lands in FLUSH; stall ignored there
        step(0,0,1,0,0, 1, RED,  0, 0, 1, 1);
        step(0,0,1,0,0, 2, RED,  0, 1, 1, 1);
        step(0,1,0,0,0, 2, HLD,  0, 2, 1, 0);
        step(0,0,0,0,0, 1, NRM,  0, 2, 1, 1);
        @(posedge clk);
        #1;
        stall_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
